// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0, MSB-first, 8-bit slave with oversampled inputs.
// Received bytes are delivered as a one-cycle rx_valid strobe. In the same transfer,
// the locally queued tx byte (or IDLE_BYTE when nothing is queued) is shifted out on miso.
// Optional feature macro: SPI_SLAVE_OVERRUN_EN (adds rx_ack input and sticky overrun output).
module spi_slave_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic       rx_ack,
    output logic       overrun,
`endif
    output logic       busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   ss_prev_q;
    logic                   sck_prev_q;

    logic ss_s, sck_s, mosi_s;
    logic ss_fall, ss_rise, sck_rise, sck_fall;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] shift_tx_q, shift_tx_d;
    logic       miso_q, miso_d;
    logic       reload_q, reload_d;
    logic [7:0] txbuf_q, txbuf_d;
    logic       txfull_q, txfull_d;

    logic       consume;
    logic       sample_en;
    logic [7:0] next_tx;

    // Synchronize the asynchronous SPI pins and keep the previous sample for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ss_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign ss_fall  = ss_prev_q & ~ss_s;
    assign ss_rise  = ~ss_prev_q & ss_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;
    assign next_tx  = txfull_q ? txbuf_q : IDLE_BYTE;

    // Next-state logic for the transfer FSM, shift registers and tx holding buffer.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        shift_tx_d = shift_tx_q;
        miso_d     = miso_q;
        reload_d   = reload_q;
        txbuf_d    = txbuf_q;
        txfull_d   = txfull_q;
        consume    = 1'b0;
        sample_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    consume    = 1'b1;
                    shift_tx_d = next_tx;
                    miso_d     = next_tx[7];
                    bit_cnt_d  = '0;
                    reload_d   = 1'b0;
                    state_d    = SHIFT;
                    // An sck rise seen together with the ss fall is sampled after the load.
                    sample_en  = sck_rise;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                    reload_d  = 1'b0;
                end else if (!ss_s) begin
                    if (sck_rise) begin
                        sample_en = 1'b1;
                    end else if (sck_fall) begin
                        if (reload_q) begin
                            consume    = 1'b1;
                            shift_tx_d = next_tx;
                            miso_d     = next_tx[7];
                            reload_d   = 1'b0;
                        end else if (bit_cnt_q != 3'd0) begin
                            shift_tx_d = {shift_tx_q[6:0], 1'b0};
                            miso_d     = shift_tx_q[6];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (sample_en) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_s};
            if (bit_cnt_d == 3'd7) begin
                rx_data_d  = {rx_shift_q, mosi_s};
                rx_valid_d = 1'b1;
                bit_cnt_d  = '0;
                reload_d   = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_d + 3'd1;
            end
        end

        // Consume first, then a same-cycle load refills the now-empty buffer.
        if (consume) begin
            txfull_d = 1'b0;
        end
        if (tx_load && !txfull_d) begin
            txbuf_d  = tx_data;
            txfull_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            shift_tx_q <= '0;
            miso_q     <= 1'b0;
            reload_q   <= 1'b0;
            txbuf_q    <= '0;
            txfull_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            shift_tx_q <= shift_tx_d;
            miso_q     <= miso_d;
            reload_q   <= reload_d;
            txbuf_q    <= txbuf_d;
            txfull_q   <= txfull_d;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_pending_q, rx_pending_d;
    logic overrun_q, overrun_d;

    // Track unacknowledged bytes; a completion while one is pending flags a sticky overrun.
    always_comb begin
        rx_pending_d = rx_pending_q;
        overrun_d    = overrun_q;
        if (rx_ack) begin
            rx_pending_d = 1'b0;
            overrun_d    = 1'b0;
        end else if (rx_valid_q && rx_pending_q) begin
            overrun_d = 1'b1;
        end
        if (rx_valid_q) begin
            rx_pending_d = 1'b1;
        end
    end

    // Pending/overrun registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_pending_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_pending_q <= rx_pending_d;
            overrun_q    <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign miso     = miso_q;
    assign tx_ready = ~txfull_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = ~ss_s;

endmodule
